// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scan driver.
//
// Contents:
//   SEG_0 .. SEG_F  active-low cathode patterns {a,b,c,d,e,f,g} for hex digits
//   SEG_BLANK       all segments off
//   idx_width()     width of a slot index for a given digit count (minimum 1)

package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // A single-digit display still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// seg7_hex_encode: combinational hex nibble to active-low seven-segment map.
//
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg     out 7  active-low cathodes {a,b,c,d,e,f,g}

module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver.
//
// Scans NUM_DIGITS digits, one per refresh slot of REFRESH_DIV cycles, onto shared
// active-low cathodes and per-digit active-low anodes. The first BLANK_CYCLES of each
// slot are dark to suppress ghosting. Inputs are snapshotted once per frame so the
// display never tears.
//
// Ports:
//   clk        in   1              system clock
//   rst_n      in   1              synchronous active-low reset
//   value      in   4*NUM_DIGITS   hex nibbles, nibble k = digit k, digit 0 rightmost
//   dp_in      in   NUM_DIGITS     decimal point request per digit (1 = lit)
//   digit_en   in   NUM_DIGITS     per-digit enable (0 = dark)
//   lz_blank   in   1              leading-zero blanking enable
//   anode      out  NUM_DIGITS     active-low digit select, at most one bit low
//   cathode    out  7              active-low segments {a,b,c,d,e,f,g}
//   dp_n       out  1              active-low decimal point
//   scan_done  out  1              one-cycle pulse after each frame snapshot

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp_n,
  output logic                    scan_done
);

  localparam int unsigned SW = idx_width(NUM_DIGITS);
  localparam int unsigned PW = $clog2(REFRESH_DIV);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_LIT  = PW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

  // Scan state
  logic [PW-1:0] presc_q;
  logic [SW-1:0] slot_q;
  // Low after reset until the first post-reset snapshot has been taken.
  logic          run_q;

  // Frame snapshot
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    lz_q;

  logic last_presc;
  logic last_slot;
  logic snap;

  assign last_presc = (presc_q == PRESC_LAST);
  assign last_slot  = (slot_q == SLOT_LAST);
  // Capture on the first edge out of reset and on every frame wrap.
  assign snap       = !run_q || (last_presc && last_slot);

  // Leading-zero mask: digit k is blanked when it and every higher nibble are zero.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zero_run   = zero_run && (value_q[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_q && zero_run;
    end
  end

  // Select the snapshot fields for the current slot.
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_lz;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] sel_anode;

  always_comb begin
    cur_nib   = 4'h0;
    cur_en    = 1'b0;
    cur_lz    = 1'b0;
    cur_dp    = 1'b0;
    sel_anode = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (slot_q == SW'(k)) begin
        cur_nib      = value_q[4*k +: 4];
        cur_en       = en_q[k];
        cur_lz       = lz_mask[k];
        cur_dp       = dp_q[k];
        sel_anode[k] = 1'b0;
      end
    end
  end

  logic [6:0] cur_seg;

  seg7_hex_encode u_hex_encode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  logic show;
  assign show = (presc_q >= PRESC_LIT) && cur_en && !cur_lz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      slot_q    <= '0;
      run_q     <= 1'b0;
      value_q   <= '0;
      dp_q      <= '0;
      en_q      <= '0;
      lz_q      <= 1'b0;
      anode     <= '1;
      cathode   <= SEG_BLANK;
      dp_n      <= 1'b1;
      scan_done <= 1'b0;
    end else begin
      scan_done <= snap;

      if (snap) begin
        value_q <= value;
        dp_q    <= dp_in;
        en_q    <= digit_en;
        lz_q    <= lz_blank;
      end

      if (!run_q) begin
        // Counters hold at slot 0 / prescaler 0 so the first frame is full length.
        run_q   <= 1'b1;
        anode   <= '1;
        cathode <= SEG_BLANK;
        dp_n    <= 1'b1;
      end else begin
        if (last_presc) begin
          presc_q <= '0;
          slot_q  <= last_slot ? '0 : slot_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end

        if (show) begin
          anode   <= sel_anode;
          cathode <= cur_seg;
          dp_n    <= !cur_dp;
        end else begin
          anode   <= '1;
          cathode <= SEG_BLANK;
          dp_n    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
// A behavioural model derives the expected outputs from the edge count since reset
// release; directed scenarios pin specific values, then a random phase runs.

module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int B  = 1;
  localparam int NR = N * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_n;
  logic        scan_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .anode     (anode),
    .cathode   (cathode),
    .dp_n      (dp_n),
    .scan_done (scan_done)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] seg_tab [16];

  // Model state
  bit          known = 1'b0;
  int          model_e = -1;
  logic [15:0] s_val;
  logic [3:0]  s_dp, s_en;
  logic        s_lz;
  logic [3:0]  exp_an;
  logic [6:0]  exp_cat;
  logic        exp_dp, exp_sd;
  int          m_e, m_c, m_p, m_slot, m_pre;
  bit          m_vis;
  logic [3:0]  m_nib;

  // Edge e after release: e=0 captures and is dark; edge e>=1 shows position e-1
  // of the frame; snapshots (and scan_done) fall on every multiple of NR.
  always @(posedge clk) begin
    if (!rst_n) begin
      known   = 1'b1;
      model_e = -1;
      s_val   = '0;
      s_dp    = '0;
      s_en    = '0;
      s_lz    = 1'b0;
      exp_an  = 4'hf;
      exp_cat = 7'h7f;
      exp_dp  = 1'b1;
      exp_sd  = 1'b0;
    end else if (known) begin
      m_e     = model_e + 1;
      exp_an  = 4'hf;
      exp_cat = 7'h7f;
      exp_dp  = 1'b1;
      if (m_e > 0) begin
        m_c    = m_e - 1;
        m_p    = m_c % NR;
        m_slot = m_p / R;
        m_pre  = m_p % R;
        m_vis  = s_en[m_slot] && !(s_lz && m_slot >= 1 && (s_val >> (4 * m_slot)) == 16'h0);
        if (m_pre >= B && m_vis) begin
          m_nib          = 4'(s_val >> (4 * m_slot));
          exp_an[m_slot] = 1'b0;
          exp_cat        = seg_tab[m_nib];
          exp_dp         = !s_dp[m_slot];
        end
      end
      exp_sd = (m_e % NR == 0);
      if (m_e % NR == 0) begin
        s_val = value;
        s_dp  = dp_in;
        s_en  = digit_en;
        s_lz  = lz_blank;
      end
      model_e = m_e;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
  endtask

  // Cycle-by-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (known) begin
      chk("cyc_anode", 16'(anode), 16'(exp_an));
      chk("cyc_cathode", 16'(cathode), 16'(exp_cat));
      chk("cyc_dp_n", 16'(dp_n), 16'(exp_dp));
      chk("cyc_scan_done", 16'(scan_done), 16'(exp_sd));
    end
  end

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] ca,
                     input logic dp, input logic sd);
    chk({name, ".anode"}, 16'(anode), 16'(an));
    chk({name, ".cathode"}, 16'(cathode), 16'(ca));
    chk({name, ".dp_n"}, 16'(dp_n), 16'(dp));
    chk({name, ".scan_done"}, 16'(scan_done), 16'(sd));
    chk({name, ".model"}, 16'({exp_an, exp_cat, exp_dp, exp_sd}), 16'({an, ca, dp, sd}));
  endtask

  // Return just after the outputs of release-relative edge e have settled.
  task automatic wait_edge(input int e);
    int g;
    g = 0;
    while (!(rst_n && known && model_e == e) && g < 200) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (g >= 200) begin
      total_cnt++;
      $display("FAIL wait_edge: reached edge %0d, required %0d", model_e, e);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reset with arbitrary inputs
    value    = 16'h5a5a;
    dp_in    = 4'hf;
    digit_en = 4'hf;
    lz_blank = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      lit("reset", 4'hf, 7'h7f, 1'b1, 1'b0);
    end

    // Basic scan of 12AF
    value    = 16'h12AF;
    dp_in    = 4'h0;
    digit_en = 4'hf;
    lz_blank = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(0);  lit("s1_e0", 4'hf, 7'h7f, 1'b1, 1'b1);
    wait_edge(1);  lit("s1_dark0", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(2);  lit("s1_slot0", 4'b1110, 7'b0111000, 1'b1, 1'b0);
    wait_edge(5);  lit("s1_dark1", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(6);  lit("s1_slot1", 4'b1101, 7'b0001000, 1'b1, 1'b0);
    wait_edge(10); lit("s1_slot2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
    wait_edge(14); lit("s1_slot3", 4'b0111, 7'b1001111, 1'b1, 1'b0);
    wait_edge(16); lit("s1_done1", 4'b0111, 7'b1001111, 1'b1, 1'b1);
    wait_edge(32); lit("s1_done2", 4'b0111, 7'b1001111, 1'b1, 1'b1);

    // Leading-zero blanking
    value    = 16'h0030;
    lz_blank = 1'b1;
    do_reset(2);
    wait_edge(2);  lit("lz_slot0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    wait_edge(6);  lit("lz_slot1", 4'b1101, 7'b0000110, 1'b1, 1'b0);
    wait_edge(10); lit("lz_slot2", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(14); lit("lz_slot3", 4'hf, 7'h7f, 1'b1, 1'b0);
    value = 16'h0000;
    wait_edge(18); lit("lz0_slot0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    wait_edge(22); lit("lz0_slot1", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(26); lit("lz0_slot2", 4'hf, 7'h7f, 1'b1, 1'b0);

    // Tearing: change mid-frame
    value    = 16'h1111;
    lz_blank = 1'b0;
    do_reset(1);
    wait_edge(9);
    value = 16'h2222;
    wait_edge(10); lit("tear_slot2", 4'b1011, 7'b1001111, 1'b1, 1'b0);
    wait_edge(14); lit("tear_slot3", 4'b0111, 7'b1001111, 1'b1, 1'b0);
    wait_edge(16); lit("tear_done", 4'b0111, 7'b1001111, 1'b1, 1'b1);
    wait_edge(18); lit("tear_new0", 4'b1110, 7'b0010010, 1'b1, 1'b0);
    wait_edge(22); lit("tear_new1", 4'b1101, 7'b0010010, 1'b1, 1'b0);

    // Enables and decimal points, then reset mid-scan
    value    = 16'h8888;
    digit_en = 4'b1011;
    dp_in    = 4'b0001;
    do_reset(1);
    wait_edge(2);  lit("en_slot0", 4'b1110, 7'b0000000, 1'b0, 1'b0);
    wait_edge(6);  lit("en_slot1", 4'b1101, 7'b0000000, 1'b1, 1'b0);
    wait_edge(10); lit("en_slot2", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(11);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    lit("midrst", 4'hf, 7'h7f, 1'b1, 1'b0);
    rst_n = 1'b1;
    wait_edge(0);  lit("midrst_e0", 4'hf, 7'h7f, 1'b1, 1'b1);
    wait_edge(1);  lit("midrst_e1", 4'hf, 7'h7f, 1'b1, 1'b0);
    wait_edge(2);  lit("midrst_slot0", 4'b1110, 7'b0000000, 1'b0, 1'b0);
    wait_edge(14); lit("midrst_slot3", 4'b0111, 7'b0000000, 1'b1, 1'b0);

    // Random phase
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in    = 4'($urandom);
        digit_en = ($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom);
        lz_blank = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
